// File: rtl/mem_stage_if.sv
// Data-memory port of the MEM stage: a req/ack handshake with address,
// write data and read data. The stage is the master, the memory is the slave.
interface mem_stage_if #(
  parameter int unsigned DATA_W = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage pipeline. Runs loads/stores over a req/ack data
// memory port, stalling the pipe until ack, resolves branches into a
// one-cycle flush/redirect, and drives the MEM/WB register. A memory timeout
// raises a sticky error and stalls the pipe until reset.
module mem_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] result_x,
  input  logic [DATA_W-1:0] store_data_x,
  input  logic              mem_wr_x,
  input  logic              wb_sel_x,
  input  logic              write_x,
  input  logic [REG_W-1:0]  writeregsel_x,
  input  logic [1:0]        branch_x,
  input  logic              branch_dec_x,
  input  logic [DATA_W-1:0] br_target_x,
  mem_stage_if.master       dmem,
  output logic              stall,
  output logic              flush,
  output logic              pc_redirect,
  output logic [DATA_W-1:0] pc_target,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_write,
  output logic [REG_W-1:0]  wb_regsel,
  output logic              mem_err
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ERR
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic store;
  logic load;
  logic mem_op;
  logic taken;

  // Instruction decode and the combinational handshake / stall / branch outputs
  always_comb begin
    store  = mem_wr_x;
    load   = wb_sel_x & write_x & ~mem_wr_x;
    mem_op = store | load;

    dmem.dmem_req = ((state == S_IDLE) & mem_op) | (state == S_WAIT);
    dmem.dmem_we  = store & dmem.dmem_req;

    stall = ((state == S_IDLE) & mem_op)
          | ((state == S_WAIT) & ~dmem.dmem_ack)
          | (state == S_ERR);

    taken       = ((branch_x == 2'b01) & branch_dec_x) | branch_x[1];
    flush       = taken & ~stall;
    pc_redirect = taken & ~stall;
    pc_target   = br_target_x;
  end

  // Address and store data come straight from EX/MEM; stall keeps them stable
  assign dmem.dmem_addr  = {result_x[DATA_W-1:2], 2'b00};
  assign dmem.dmem_wdata = store_data_x;

  // Transaction FSM: counts unacknowledged WAIT cycles, ERR is sticky until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      mem_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_op) begin
            state <= S_WAIT;
            cnt   <= '0;
          end
        end
        S_WAIT: begin
          if (dmem.dmem_ack) begin
            state <= S_IDLE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state   <= S_ERR;
            mem_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ERR: begin
          state <= S_ERR;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // MEM/WB register: bubble on stall, frozen entirely once in ERR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_write  <= 1'b0;
      wb_data   <= '0;
      wb_regsel <= '0;
    end else if (state != S_ERR) begin
      if (stall) begin
        wb_write <= 1'b0;
      end else begin
        wb_write  <= write_x & ~mem_wr_x & (writeregsel_x != '0);
        wb_regsel <= writeregsel_x;
        wb_data   <= load ? dmem.dmem_rdata : result_x;
      end
    end
  end

endmodule
